// File: rtl/reduction_tree_acc.sv
// reduction_tree_acc: pipelined sum/max/min lane reduction with per-packet accumulation.
// Define REDUCE_SAT_EN for saturating sums and a sticky out_sat flag.
module reduction_tree_acc #(
  parameter int DWIDTH    = 64,
  parameter int NUM_LANES = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES*DWIDTH-1:0]   in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [1:0]                    in_op,
  output logic                          in_ready,
  output logic [DWIDTH-1:0]             out_data,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_sat,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int L = $clog2(NUM_LANES);

  function automatic logic [DWIDTH:0] add_op(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
`ifdef REDUCE_SAT_EN
    logic [DWIDTH:0] t;
    t = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
    return (t[DWIDTH] != t[DWIDTH-1]) ? {1'b1, t[DWIDTH], {(DWIDTH-1){~t[DWIDTH]}}} : {1'b0, t[DWIDTH-1:0]};
`else
    return {1'b0, a + b};
`endif
  endfunction

  // Result is {saturated, value}; only sums can saturate.
  function automatic logic [DWIDTH:0] red_op(input logic [1:0] op, input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    return op == 2'b01 ? {1'b0, ($signed(a) > $signed(b)) ? a : b} :
           op == 2'b10 ? {1'b0, ($signed(a) < $signed(b)) ? a : b} : add_op(a, b);
  endfunction

  logic       adv, accept, first_in;
  logic [1:0] pkt_op;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // The op of a packet's first beat is latched and reused for its remaining beats.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      first_in <= 1'b1;
      pkt_op   <= 2'b00;
    end else if (accept) begin
      first_in <= in_last;
      if (first_in) pkt_op <= in_op;
    end

  for (genvar k = 0; k <= L; k++) begin : g_st
    localparam int N = NUM_LANES >> k;
    logic [DWIDTH-1:0] d [N];
    logic              v, l, s;
    logic [1:0]        o;
    if (k == 0) begin : g_in
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v <= 1'b0;
          l <= 1'b0;
          s <= 1'b0;
          o <= 2'b00;
          for (int i = 0; i < N; i++) d[i] <= '0;
        end else if (adv) begin
          v <= accept;
          l <= in_last;
          s <= 1'b0;
          o <= first_in ? in_op : pkt_op;
          for (int i = 0; i < N; i++) d[i] <= in_data[i*DWIDTH +: DWIDTH];
        end
    end else begin : g_tr
      logic [DWIDTH:0] r [N];
      logic            any_s;
      always_comb begin
        any_s = g_st[k-1].s;
        for (int i = 0; i < N; i++) begin
          r[i]  = red_op(g_st[k-1].o, g_st[k-1].d[2*i], g_st[k-1].d[2*i+1]);
          any_s = any_s | r[i][DWIDTH];
        end
      end
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v <= 1'b0;
          l <= 1'b0;
          s <= 1'b0;
          o <= 2'b00;
          for (int i = 0; i < N; i++) d[i] <= '0;
        end else if (adv) begin
          v <= g_st[k-1].v;
          l <= g_st[k-1].l;
          s <= any_s;
          o <= g_st[k-1].o;
          for (int i = 0; i < N; i++) d[i] <= r[i][DWIDTH-1:0];
        end
    end
  end

  logic [DWIDTH-1:0] acc, nacc;
  logic [CNT_W-1:0]  cnt, ncnt;
  logic              acc_sat, nsat, first_beat;
  logic [DWIDTH:0]   step;

  always_comb begin
    step = red_op(g_st[L].o, acc, g_st[L].d[0]);
    nacc = first_beat ? g_st[L].d[0] : step[DWIDTH-1:0];
    ncnt = first_beat ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
    nsat = g_st[L].s | (!first_beat & (acc_sat | step[DWIDTH]));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      acc_sat    <= 1'b0;
      first_beat <= 1'b1;
      out_data   <= '0;
      out_count  <= '0;
      out_sat    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (adv) begin
      out_valid <= g_st[L].v && g_st[L].l;
      if (g_st[L].v) begin
        acc        <= nacc;
        cnt        <= ncnt;
        acc_sat    <= nsat;
        first_beat <= g_st[L].l;
        if (g_st[L].l) begin
          out_data  <= nacc;
          out_count <= ncnt;
          out_sat   <= nsat;
        end
      end
    end
endmodule

// File: tb/tb_reduction_tree_acc.sv
// tb_reduction_tree_acc: directed checks of reduction_tree_acc (default 8 x 64-bit lanes).
module tb_reduction_tree_acc;
  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_data;
  logic         in_valid, in_last, in_ready;
  logic [1:0]   in_op;
  logic [63:0]  out_data;
  logic [15:0]  out_count;
  logic         out_sat, out_valid, out_ready;
  int           n_cmp = 0, n_bad = 0, lat;

  always #5 clk = ~clk;

  reduction_tree_acc dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_op(in_op), .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [511:0] rep(input logic [63:0] v);
    return {8{v}};
  endfunction

  function automatic logic [511:0] mk(input longint a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [511:0] d, input logic l, input logic [1:0] op);
    int n = 0;
    in_data = d; in_last = l; in_op = op; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_op = 2'b00; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    beat(mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 2'b00);
    wait_out();
    chk("sum1_latency", 64'(lat), 64'd4);
    chk("sum1_data", out_data, 64'd36);
    chk("sum1_count", 64'(out_count), 64'd1);
    chk("sum1_sat", 64'(out_sat), 64'd0);
    @(posedge clk); #1;
    chk("sum1_clear", 64'(out_valid), 64'd0);

    beat(rep(64'd1), 1'b0, 2'b00);
    beat(rep(64'd2), 1'b0, 2'b01);
    beat(rep(64'd3), 1'b1, 2'b00);
    wait_out();
    chk("sum3_data", out_data, 64'd48);
    chk("sum3_count", 64'(out_count), 64'd3);

    beat(mk(-5, 7, -100, 3, 0, 6, -1, 2), 1'b1, 2'b01);
    wait_out();
    chk("max_data", out_data, 64'd7);
    beat(mk(-5, 7, -100, 3, 0, 6, -1, 2), 1'b1, 2'b10);
    wait_out();
    chk("min_data", out_data, 64'hFFFF_FFFF_FFFF_FF9C);
    beat(mk(-9, -3, -7, -3, -12, -4, -8, -5), 1'b1, 2'b01);
    wait_out();
    chk("max_neg_tie", out_data, 64'hFFFF_FFFF_FFFF_FFFD);

    @(posedge clk); #1;
    out_ready = 1'b0;
    beat(rep(64'd1), 1'b1, 2'b00);
    beat(rep(64'd2), 1'b1, 2'b00);
    beat(rep(64'd3), 1'b1, 2'b00);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_data", out_data, 64'd8);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_data", out_data, 64'd16);
    @(posedge clk); #1;
    chk("bp_third_valid", 64'(out_valid), 64'd1);
    chk("bp_third_data", out_data, 64'd24);
    @(posedge clk); #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

    beat(rep(64'h7FFF_FFFF_FFFF_FFFF), 1'b1, 2'b00);
    wait_out();
`ifdef REDUCE_SAT_EN
    chk("ovf_pos_data", out_data, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf_pos_sat", 64'(out_sat), 64'd1);
`else
    chk("ovf_pos_data", out_data, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ovf_pos_sat", 64'(out_sat), 64'd0);
`endif
    beat(rep(64'h8000_0000_0000_0000), 1'b1, 2'b00);
    wait_out();
`ifdef REDUCE_SAT_EN
    chk("ovf_neg_data", out_data, 64'h8000_0000_0000_0000);
    chk("ovf_neg_sat", 64'(out_sat), 64'd1);
`else
    chk("ovf_neg_data", out_data, 64'd0);
    chk("ovf_neg_sat", 64'(out_sat), 64'd0);
`endif
    beat(rep(64'd5), 1'b1, 2'b00);
    wait_out();
    chk("post_ovf_data", out_data, 64'd40);
    chk("post_ovf_sat", 64'(out_sat), 64'd0);

    beat(rep(64'd1), 1'b0, 2'b00);
    beat(rep(64'd1), 1'b0, 2'b00);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_sat", 64'(out_sat), 64'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    beat(rep(64'd1), 1'b1, 2'b00);
    wait_out();
    chk("fresh_latency", 64'(lat), 64'd4);
    chk("fresh_data", out_data, 64'd8);
    chk("fresh_count", 64'(out_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
